// File: rtl/timer_counter_pkg.sv
// Shared types and constants for the memory-mapped countdown timer.
// Register map, CTRL bit layout and FSM encoding live here so bus and core agree.
package tc_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    // Field order matches the CTRL word: {IM, Mode, Enable} at bits [3:0].
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_counter_if.sv
// Word-addressed register bus between the system bridge and the timer.
// The bridge is the master; the timer answers reads combinationally.
interface timer_counter_if;

    logic [1:0]               addr;
    logic                     we;
    logic [tc_pkg::DATA_W-1:0] din;
    logic [tc_pkg::DATA_W-1:0] dout;
    logic                     irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);

endinterface

// File: rtl/timer_counter.sv
// Countdown timer: CTRL/PRESET/COUNT register file plus a four-state FSM.
// The interrupt is a level (irq_flag gated by IM) feeding one CP0 HWInt bit.
module timer_counter
    import tc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    timer_counter_if.slave    bus
);

    tc_state_e         state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_flag_q, irq_flag_d;
    logic              wr_ctrl, wr_preset;

    assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
    assign wr_preset = bus.we && (bus.addr == ADDR_PRESET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            IDLE: begin
                if (ctrl_q.en) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q.en) begin
                    state_d = IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // Terminal step also covers PRESET=0, so COUNT never wraps.
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                if (ctrl_q.mode == MODE_PERIODIC) irq_flag_d = 1'b0;
                else                              ctrl_d.en  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus writes are applied last so they override same-edge FSM updates.
        if (wr_ctrl) begin
            ctrl_d     = ctrl_t'(bus.din[CTRL_IM:CTRL_EN]);
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d   = bus.din[CNT_W-1:0];
            irq_flag_d = 1'b0;
        end
    end

    always_comb begin
        case (bus.addr)
            ADDR_CTRL:   bus.dout = DATA_W'(ctrl_q);
            ADDR_PRESET: bus.dout = DATA_W'(preset_q);
            ADDR_COUNT:  bus.dout = DATA_W'(count_q);
            default:     bus.dout = '0;
        endcase
    end

    assign bus.irq = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// presets, with expectations computed from latency/period arithmetic.
module tb_timer_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    timer_counter_if bif();

    timer_counter #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bif.addr = a;
        bif.din  = d;
        bif.we   = 1'b1;
        tick();
        bif.we   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bif.addr = a;
        #1;
        v = bif.dout;
    endtask

    function automatic int eff(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        bif.we = 1'b0; bif.addr = 2'd0; bif.din = '0;
        #3;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            total++;
            if (v !== 32'h0) begin bad++; $display("FAIL reset_dout addr=%0d got=%h exp=0", a, v); end
        end
        total++;
        if (bif.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bif.irq); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        repeat (3) tick();
        rd(2'd2, v);
        total++;
        if (v !== 32'd9) begin bad++; $display("FAIL midrst_pre count got=%0d exp=9", v); end
        reset = 1'b1;
        #1;
        rd(2'd2, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", v); end
        rd(2'd0, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("FAIL midrst_ctrl got=%h exp=0", v); end
        rd(2'd1, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("FAIL midrst_preset got=%h exp=0", v); end
        total++;
        if (bif.irq !== 1'b0) begin bad++; $display("FAIL midrst_irq got=%b exp=0", bif.irq); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        int n_list[4];
        n_list[0] = 5;
        for (int i = 1; i < 4; i++) n_list[i] = $urandom_range(2, 15);
        foreach (n_list[i]) begin
            int n, fire, expc;
            n = n_list[i];
            fire = eff(n) + 2;
            bus_write(2'd1, n);
            bus_write(2'd0, 32'h9);
            for (int k = 1; k <= fire + 2; k++) begin
                tick();
                if (k >= 2) begin
                    expc = (n - (k - 2) > 0) ? n - (k - 2) : 0;
                    rd(2'd2, v);
                    total++;
                    if (v !== expc) begin bad++; $display("FAIL oneshot_count n=%0d k=%0d got=%0d exp=%0d", n, k, v, expc); end
                end
                total++;
                if (bif.irq !== (k >= fire)) begin bad++; $display("FAIL oneshot_irq n=%0d k=%0d got=%b exp=%b", n, k, bif.irq, k >= fire); end
            end
            repeat (2) tick();
            rd(2'd0, v);
            total++;
            if (v !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl n=%0d got=%h exp=8", n, v); end
            total++;
            if (bif.irq !== 1'b1) begin bad++; $display("FAIL oneshot_hold n=%0d got=%b exp=1", n, bif.irq); end
            bus_write(2'd0, 32'h8);
            total++;
            if (bif.irq !== 1'b0) begin bad++; $display("FAIL oneshot_clear n=%0d got=%b exp=0", n, bif.irq); end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        int n_list[3];
        n_list[0] = 3;
        n_list[1] = $urandom_range(0, 6);
        n_list[2] = $urandom_range(0, 6);
        foreach (n_list[i]) begin
            int first, per;
            logic expi;
            first = eff(n_list[i]) + 2;
            per   = eff(n_list[i]) + 3;
            bus_write(2'd1, n_list[i]);
            bus_write(2'd0, 32'hB);
            for (int k = 1; k <= first + 2 * per + 1; k++) begin
                tick();
                expi = (k >= first) && (((k - first) % per) == 0);
                total++;
                if (bif.irq !== expi) begin bad++; $display("FAIL periodic_irq n=%0d k=%0d got=%b exp=%b", n_list[i], k, bif.irq, expi); end
            end
            rd(2'd0, v);
            total++;
            if (v !== 32'hB) begin bad++; $display("FAIL periodic_ctrl n=%0d got=%h exp=b", n_list[i], v); end
            bus_write(2'd0, 32'h0);
            repeat (3) tick();
        end
    endtask

    task automatic test_masked();
        logic [31:0] v;
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (bif.irq !== 1'b0) begin bad++; $display("FAIL masked_irq k=%0d got=%b exp=0", k, bif.irq); end
        end
        rd(2'd0, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL masked_ctrl got=%h exp=0", v); end
        bus_write(2'd0, 32'h8);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bif.irq !== 1'b0) begin bad++; $display("FAIL masked_unmask k=%0d got=%b exp=0", k, bif.irq); end
            tick();
        end
    endtask

    task automatic test_pause();
        logic [31:0] v;
        bus_write(2'd1, 32'd20);
        bus_write(2'd0, 32'h9);
        repeat (6) tick();
        rd(2'd2, v);
        total++;
        if (v !== 32'd16) begin bad++; $display("FAIL pause_pre got=%0d exp=16", v); end
        // Enable still reads 1 on this edge, so one more decrement lands.
        bus_write(2'd0, 32'h8);
        for (int k = 0; k < 5; k++) begin
            tick();
            rd(2'd2, v);
            total++;
            if (v !== 32'd15) begin bad++; $display("FAIL pause_freeze k=%0d got=%0d exp=15", k, v); end
        end
        bus_write(2'd2, 32'h55);
        rd(2'd2, v);
        total++;
        if (v !== 32'd15) begin bad++; $display("FAIL count_ro got=%0d exp=15", v); end
        bus_write(2'd1, 32'd4);
        rd(2'd2, v);
        total++;
        if (v !== 32'd15) begin bad++; $display("FAIL pause_preset got=%0d exp=15", v); end
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) begin
                rd(2'd2, v);
                total++;
                if (v !== 32'd4) begin bad++; $display("FAIL pause_reload got=%0d exp=4", v); end
            end
            total++;
            if (bif.irq !== (k == 6)) begin bad++; $display("FAIL pause_irq k=%0d got=%b exp=%b", k, bif.irq, k == 6); end
        end
        bus_write(2'd0, 32'h0);
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        repeat (3) tick();
        total++;
        if (bif.irq !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b exp=0", bif.irq); end
        tick();
        total++;
        if (bif.irq !== 1'b1) begin bad++; $display("FAIL b2b_fire got=%b exp=1", bif.irq); end
        // CTRL write coincides with the INT edge: written Enable must survive.
        bus_write(2'd0, 32'h9);
        rd(2'd0, v);
        total++;
        if (v !== 32'h9) begin bad++; $display("FAIL b2b_ctrl got=%h exp=9", v); end
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (bif.irq !== 1'b0 && k < 4) begin bad++; $display("FAIL b2b_gap k=%0d got=%b exp=0", k, bif.irq); end
            tick();
        end
        total++;
        if (bif.irq !== 1'b1) begin bad++; $display("FAIL b2b_refire got=%b exp=1", bif.irq); end
        bus_write(2'd0, 32'h0);
        repeat (2) tick();
    endtask

    task automatic test_edge_presets();
        logic [31:0] v;
        for (int n = 0; n < 2; n++) begin
            bus_write(2'd1, n);
            bus_write(2'd0, 32'h9);
            for (int k = 1; k <= 3; k++) begin
                tick();
                total++;
                if (bif.irq !== (k == 3)) begin bad++; $display("FAIL edge_irq n=%0d k=%0d got=%b exp=%b", n, k, bif.irq, k == 3); end
            end
            bus_write(2'd2, 32'h55);
            rd(2'd2, v);
            total++;
            if (v !== 32'd0) begin bad++; $display("FAIL edge_count n=%0d got=%0d exp=0", n, v); end
            bus_write(2'd0, 32'h0);
        end
    endtask

    task automatic test_regs();
        logic [31:0] v, p, c;
        for (int i = 0; i < 6; i++) begin
            p = $urandom;
            bus_write(2'd1, p);
            rd(2'd1, v);
            total++;
            if (v !== p) begin bad++; $display("FAIL reg_preset got=%h exp=%h", v, p); end
            c = $urandom & 32'hFFFF_FFFE;
            bus_write(2'd0, c);
            rd(2'd0, v);
            total++;
            if (v !== (c & 32'hE)) begin bad++; $display("FAIL reg_ctrl got=%h exp=%h", v, c & 32'hE); end
            bus_write(2'd3, $urandom);
            rd(2'd3, v);
            total++;
            if (v !== 32'h0) begin bad++; $display("FAIL reg_rsvd got=%h exp=0", v); end
        end
        bus_write(2'd0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_oneshot();
        test_periodic();
        test_masked();
        test_pause();
        test_back_to_back();
        test_edge_presets();
        test_regs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
